// File: rtl/mems_rom_arbiter.sv
// Round-robin arbiter sharing one single-port waveform ROM among N_REQ DAC channels,
// with a latency-matched in-flight pipeline. Optional feature macro: MEMS_ARB_MIRROR_EN.
module mems_rom_arbiter #(
  parameter int N_REQ = 6,
  parameter int AW = 14,
  parameter int DW = 8,
  parameter int ROM_LAT = 1,
  parameter logic [DW-1:0] MIRROR_SUM = DW'(8'hB4)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ-1:0]    mirror,
  input  logic                hold,
  output logic [N_REQ-1:0]    gnt,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic                busy
);

  // Handshake: req/addr/mirror are held by the channel until its gnt bit is seen;
  // rsp_valid is a single-cycle strobe with no backpressure.
  localparam int DEPTH = ROM_LAT + 1;

  logic [2:0]         ptr;
  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   rot;
  logic [2*N_REQ-1:0] dbl;
  logic [2:0]         off;
  logic [3:0]         sum;
  logic [2:0]         pick;
  logic [2:0]         ptr_next;
  logic               found;
  logic [AW-1:0]      pick_addr;
  logic [DW-1:0]      tail_data;

  logic [DEPTH-1:0]   slot_valid;
  logic [2:0]         slot_idx [DEPTH];

  // Rotate the eligible set so the search starts at ptr; lowest set bit wins.
  always_comb begin
    eligible = req & ~{N_REQ{hold}};
    dbl = {eligible, eligible};
    rot = N_REQ'(dbl >> ptr);
    found = |rot;
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
    pick = sum[2:0];
    ptr_next = (pick == 3'(N_REQ - 1)) ? 3'd0 : pick + 3'd1;
    pick_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == 3'(i)) pick_addr = addr[i*AW +: AW];
    end
  end

`ifdef MEMS_ARB_MIRROR_EN
  logic [DEPTH-1:0] slot_mir;

  always_comb begin
    tail_data = slot_mir[DEPTH-1] ? DW'(MIRROR_SUM - rom_data) : rom_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_mir <= '0;
    else        slot_mir <= {slot_mir[DEPTH-2:0], found & mirror[pick]};
  end
`else
  logic unused_mirror;
  assign unused_mirror = ^mirror;

  always_comb begin
    tail_data = rom_data;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      gnt        <= '0;
      rom_addr   <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      slot_valid <= '0;
      for (int s = 0; s < DEPTH; s++) slot_idx[s] <= '0;
    end else begin
      if (found) begin
        gnt      <= N_REQ'(1) << pick;
        rom_addr <= pick_addr;
        ptr      <= ptr_next;
      end else begin
        gnt      <= '0;
      end
      slot_valid  <= {slot_valid[DEPTH-2:0], found};
      slot_idx[0] <= pick;
      for (int s = 1; s < DEPTH; s++) slot_idx[s] <= slot_idx[s-1];
      // The tail slot lines up with the cycle its ROM byte is valid.
      if (slot_valid[DEPTH-1]) begin
        rsp_valid <= N_REQ'(1) << slot_idx[DEPTH-1];
        rsp_data  <= tail_data;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

  assign busy = |slot_valid;

endmodule

// File: tb/tb_mems_rom_arbiter.sv
// Bench for mems_rom_arbiter: directed test-plan steps then random traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_mems_rom_arbiter;
  localparam int N_REQ = 6;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int ROM_LAT = 1;
  localparam logic [7:0] MIRROR_SUM = 8'hB4;

  logic                clk;
  logic                rst_n;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ-1:0]    mirror;
  logic                hold;
  logic [N_REQ-1:0]    gnt;
  logic [AW-1:0]       rom_addr;
  logic [DW-1:0]       rom_data;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic                busy;

  int total = 0;
  int bad = 0;

  mems_rom_arbiter #(
    .N_REQ(N_REQ), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT), .MIRROR_SUM(MIRROR_SUM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .mirror(mirror), .hold(hold),
    .gnt(gnt), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: fixed contents, ROM_LAT edges of read latency
  function automatic logic [7:0] rom_fn(input logic [13:0] a);
    case (a)
      14'h0123: rom_fn = 8'h5A;
      14'h0200: rom_fn = 8'h34;
      14'h0201: rom_fn = 8'hC0;
      default:  rom_fn = 8'(a[7:0] * 8'd37) ^ {2'b00, a[13:8]};
    endcase
  endfunction

  logic [DW-1:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_fn(rom_addr);
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  // scoreboard: {due_cycle[31:16], channel[15:8], expected byte[7:0]}
  logic [31:0] exp_q[$];
  int m_ptr;
  int cyc;
  logic [N_REQ-1:0] exp_gnt;
  logic [AW-1:0]    exp_rom_addr;
  logic [N_REQ-1:0] exp_rsp_valid;
  logic [DW-1:0]    exp_rsp_data;
  logic             exp_busy;

  task automatic model_reset();
    exp_q.delete();
    m_ptr = 0;
    exp_gnt = '0;
    exp_rom_addr = '0;
    exp_rsp_valid = '0;
    exp_rsp_data = '0;
    exp_busy = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] e;
    logic [7:0] d;
    bit done;
    int c;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    exp_rsp_valid = '0;
    if (exp_q.size() > 0 && exp_q[0][31:16] == cyc[15:0]) begin
      e = exp_q.pop_front();
      exp_rsp_valid = N_REQ'(1) << e[15:8];
      exp_rsp_data = e[7:0];
    end
    exp_gnt = '0;
    done = 1'b0;
    if (!hold) begin
      for (int i = 0; i < N_REQ; i++) begin
        c = (m_ptr + i) % N_REQ;
        if (!done && req[c]) begin
          done = 1'b1;
          exp_gnt = N_REQ'(1) << c;
          exp_rom_addr = addr[c*AW +: AW];
          d = rom_fn(addr[c*AW +: AW]);
`ifdef MEMS_ARB_MIRROR_EN
          if (mirror[c]) d = 8'(MIRROR_SUM - d);
`endif
          exp_q.push_back({16'(cyc + ROM_LAT + 1), 8'(c), d});
          m_ptr = (c + 1) % N_REQ;
        end
      end
    end
    exp_busy = (exp_q.size() != 0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
    check("rsp_data", 32'(rsp_data), 32'(exp_rsp_data));
    check("busy", 32'(busy), 32'(exp_busy));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    addr[ch*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 5))
      0: rand_addr = 14'h0123;
      1: rand_addr = 14'h0200;
      2: rand_addr = 14'h0201;
      default: rand_addr = AW'($urandom_range(0, 16383));
    endcase
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_random();
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        if (exp_gnt[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            set_addr(i, rand_addr());
            mirror[i] = 1'($urandom_range(0, 1));
          end else begin
            req[i] = 1'b0;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        req[i] = 1'b1;
        set_addr(i, rand_addr());
        mirror[i] = 1'($urandom_range(0, 1));
      end
    end
    hold = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    int strobes;
    int inflight;
    rst_n = 1'b1;
    req = '0;
    addr = '0;
    mirror = '0;
    hold = 1'b0;
    cyc = 0;
    model_reset();
    #2;
    pulse_reset();
    tick();

    // single request, ch2 @ 0x123
    req = 6'b000100;
    set_addr(2, 14'h0123);
    tick();
    check("single_gnt", 32'(gnt), 32'b000100);
    check("single_addr", 32'(rom_addr), 32'h0123);
    req = '0;
    tick();
    tick();
    check("single_rsp_valid", 32'(rsp_valid), 32'b000100);
    check("single_rsp_data", 32'(rsp_data), 32'h5A);
    tick();

    // all six requesting from reset: strict rotation, busy held
    pulse_reset();
    for (int i = 0; i < N_REQ; i++) set_addr(i, AW'(14'h0100 + i));
    req = '1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("rr_gnt", 32'(gnt), 32'(1) << (i % N_REQ));
      check("rr_busy", 32'(busy), 32'd1);
      if (i >= 2) check("rr_rsp", 32'(rsp_valid), 32'(1) << ((i - 2) % N_REQ));
    end
    req = '0;
    repeat (3) tick();

    // ch1 grant moves ptr to 2, so ch4 beats ch1 next
    req = 6'b000010;
    set_addr(1, 14'h0011);
    set_addr(4, 14'h0044);
    tick();
    check("pri_first", 32'(gnt), 32'b000010);
    req = 6'b010010;
    tick();
    check("pri_ch4", 32'(gnt), 32'b010000);
    req = 6'b000010;
    tick();
    check("pri_ch1", 32'(gnt), 32'b000010);
    req = '0;
    repeat (3) tick();

    // hold with reads in flight: pipeline drains, no new grants
    req = '1;
    repeat (3) tick();
    hold = 1'b1;
    inflight = exp_q.size();
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_gnt", 32'(gnt), 32'd0);
      if (rsp_valid != '0) strobes++;
    end
    check("hold_strobes", 32'(strobes), 32'(inflight));
    check("hold_busy", 32'(busy), 32'd0);
    hold = 1'b0;
    tick();
    req = '0;
    repeat (3) tick();

    // reset the cycle after a grant drops the read; restart at ch0
    req = 6'b001000;
    set_addr(3, 14'h0333);
    tick();
    req = '0;
    pulse_reset();
    tick();
    check("post_rst_rsp", 32'(rsp_valid), 32'd0);
    req = '1;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'b000001);
    req = '0;
    repeat (3) tick();

    // mirror on ch3
    req = 6'b001000;
    mirror = 6'b001000;
    set_addr(3, 14'h0200);
    tick();
    set_addr(3, 14'h0201);
    tick();
    req = '0;
    tick();
    check("mir_valid0", 32'(rsp_valid), 32'b001000);
`ifdef MEMS_ARB_MIRROR_EN
    check("mir_data0", 32'(rsp_data), 32'h80);
`else
    check("mir_data0", 32'(rsp_data), 32'h34);
`endif
    tick();
    check("mir_valid1", 32'(rsp_valid), 32'b001000);
`ifdef MEMS_ARB_MIRROR_EN
    check("mir_data1", 32'(rsp_data), 32'hF4);
`else
    check("mir_data1", 32'(rsp_data), 32'hC0);
`endif
    mirror = '0;
    repeat (2) tick();

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive_random();
      tick();
    end
    req = '0;
    hold = 1'b0;
    repeat (4) tick();
    check("end_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
